// File: rtl/mips_pkg.sv
// Shared types for the data-cache controller: FSM states and the line record.
package mips_pkg;

    // Tag field sized for the smallest legal cache (word address minus one index bit
    // is never more than 30 bits); narrower tags are zero-extended into it.
    localparam int TAG_FIELD_W = 30;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        RESP
    } dcache_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TAG_FIELD_W-1:0] tag;
        logic [31:0]            data;
    } dcache_line_t;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: combinational read, synchronous write.
// Reset clears valid/dirty only; data words are don't-care until a line is valid.
module dcache_array
    import mips_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  dcache_line_t     wline,
    output dcache_line_t     rline
);

    dcache_line_t lines [NUM_LINES];

    assign rline = lines[idx];

    // line update; reset invalidates every entry and drops dirty state
    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines[i].valid <= 1'b0;
                lines[i].dirty <= 1'b0;
            end
        end else if (we) begin
            lines[idx] <= wline;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with one-word lines.
// Optional feature: define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module dcache_ctrl
    import mips_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     addr,
    input  logic [31:0]     write_data,
    output logic [31:0]     load_data,
    output logic            ready,
    output logic            hit,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_data_in,
    input  logic [0:3][7:0] mem_data_out,
    output logic            mem_write_en
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);

    localparam int         IDX_W    = $clog2(NUM_LINES);
    localparam int         TAG_W    = 30 - IDX_W;
    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    dcache_state_t    state;
    logic [29:0]      req_wa;
    logic             req_wr;
    logic [31:0]      req_wdata;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    dcache_line_t     rline;
    dcache_line_t     wline;
    logic             arr_we;
    logic             lookup_hit;
    logic [31:0]      fill_word;
    logic             unused_addr_bits;

    // byte offset within the word has no meaning for a word cache
    assign unused_addr_bits = ^addr[1:0];

    // IDLE looks up the live request; all later states work on the latched one
    assign idx        = (state == IDLE) ? addr[IDX_W+1:2]  : req_wa[IDX_W-1:0];
    assign tag        = (state == IDLE) ? addr[31:IDX_W+2] : req_wa[29:IDX_W];
    assign lookup_hit = rline.valid && (rline.tag == TAG_FIELD_W'(tag));
    // a write miss installs the store data over the fetched word
    assign fill_word  = req_wr ? req_wdata : mem_data_out;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (arr_we),
        .idx   (idx),
        .wline (wline),
        .rline (rline)
    );

    // line writes: store hit in IDLE, or install on the last FILL cycle
    always_comb begin
        arr_we = 1'b0;
        wline  = '0;
        if (state == IDLE && write && lookup_hit) begin
            arr_we      = 1'b1;
            wline.valid = 1'b1;
            wline.dirty = 1'b1;
            wline.tag   = TAG_FIELD_W'(tag);
            wline.data  = write_data;
        end else if (state == FILL && cnt == CNT_LAST) begin
            arr_we      = 1'b1;
            wline.valid = 1'b1;
            wline.dirty = req_wr;
            wline.tag   = TAG_FIELD_W'(tag);
            wline.data  = fill_word;
        end
    end

    // controller FSM with registered core and memory outputs
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state        <= IDLE;
            req_wa       <= '0;
            req_wr       <= 1'b0;
            req_wdata    <= '0;
            cnt          <= '0;
            ready        <= 1'b0;
            hit          <= 1'b0;
            load_data    <= '0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read || write) begin
                        req_wa    <= addr[31:2];
                        req_wr    <= write;
                        req_wdata <= write_data;
                        cnt       <= '0;
                        if (lookup_hit) begin
                            state     <= RESP;
                            ready     <= 1'b1;
                            hit       <= 1'b1;
                            load_data <= write ? write_data : rline.data;
                        end else if (rline.valid && rline.dirty) begin
                            state        <= WRITEBACK;
                            mem_write_en <= 1'b1;
                            mem_addr     <= {rline.tag[TAG_W-1:0], addr[IDX_W+1:2], 2'b00};
                            mem_data_in  <= rline.data;
                        end else begin
                            state    <= FILL;
                            mem_addr <= {addr[31:2], 2'b00};
                        end
                    end
                end
                WRITEBACK: begin
                    state        <= FILL;
                    mem_write_en <= 1'b0;
                    mem_addr     <= {req_wa, 2'b00};
                end
                FILL: begin
                    if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        ready     <= 1'b1;
                        hit       <= 1'b0;
                        load_data <= fill_word;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    ready     <= 1'b0;
                    hit       <= 1'b0;
                    load_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // completion counters, bumped once per ready pulse
    always_ff @(posedge clk) begin
        if (rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (ready) begin
            if (hit) hit_count  <= hit_count + 1'b1;
            else     miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores compared against a behavioural cache + memory model.
module tb_dcache_ctrl;

    localparam int NUM_LINES = 16;
    localparam int MEM_LAT   = 2;
    localparam int PERIOD    = 10;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            read;
    logic            write;
    logic [31:0]     addr;
    logic [31:0]     write_data;
    logic [31:0]     load_data;
    logic            ready;
    logic            hit;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic [0:3][7:0] mem_data_out;
    logic            mem_write_en;
`ifdef DCACHE_STATS_EN
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #(PERIOD/2) clk = ~clk;

    dcache_ctrl #(
        .NUM_LINES (NUM_LINES),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .read         (read),
        .write        (write),
        .addr         (addr),
        .write_data   (write_data),
        .load_data    (load_data),
        .ready        (ready),
        .hit          (hit),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [29:0]];
    logic [63:0] wb_q [$];
    longint      t_chg = 0;

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // data only becomes valid once mem_addr has been stable for MEM_LAT cycles
    always @(mem_addr) t_chg = $time;
    always @(negedge clk) begin
        if (($time - t_chg) >= longint'((MEM_LAT - 1) * PERIOD + PERIOD / 2))
            mem_data_out = mem_rd(mem_addr[31:2]);
        else
            mem_data_out = 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) begin
            wb_q.push_back({mem_addr, 32'(mem_data_in)});
            mem[mem_addr[31:2]] = mem_data_in;
        end
    end

    // ---------------- cache reference model ----------------
    bit          m_valid [NUM_LINES];
    bit          m_dirty [NUM_LINES];
    logic [29:0] m_wa    [NUM_LINES];
    logic [31:0] m_data  [NUM_LINES];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_reset();
        rst_b = 1'b1; read = 1'b0; write = 1'b0; addr = '0; write_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        model_reset();
    endtask

    task automatic check_idle_outputs(input string where);
        check({where, "_ready"}, ready, 0);
        check({where, "_hit"}, hit, 0);
        check({where, "_mem_we"}, mem_write_en, 0);
        check({where, "_mem_addr"}, mem_addr, 0);
        check({where, "_mem_din"}, 32'(mem_data_in), 0);
        check({where, "_load_data"}, load_data, 0);
    endtask

    // one core request held until ready; called 1 time unit after a posedge
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [29:0] wa;
        int          idx;
        bit          e_hit;
        bit          e_wb;
        logic [63:0] e_wb_word;
        int          e_lat;
        logic [31:0] e_load;
        int          n;
        wa        = a[31:2];
        idx       = int'(wa % NUM_LINES);
        e_hit     = m_valid[idx] && (m_wa[idx] == wa);
        e_wb      = !e_hit && m_valid[idx] && m_dirty[idx];
        e_wb_word = {m_wa[idx], 2'b00, m_data[idx]};
        e_lat     = e_hit ? 2 : (e_wb ? 3 + MEM_LAT : 2 + MEM_LAT);
        if (wr)         e_load = d;
        else if (e_hit) e_load = m_data[idx];
        else            e_load = mem_rd(wa);
        // model update: write-allocate, write-back
        m_valid[idx] = 1'b1;
        m_wa[idx]    = wa;
        m_data[idx]  = e_load;
        if (wr) m_dirty[idx] = 1'b1;
        else if (!e_hit) m_dirty[idx] = 1'b0;
        if (e_hit) exp_hits++; else exp_misses++;

        wb_q.delete();
        read = rd; write = wr; addr = a; write_data = d;
        @(posedge clk); #1;
        n = 1;
        // request is latched by now; later changes must be ignored
        addr = $urandom; write_data = $urandom;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n + 1, e_lat);
        check("hit", hit, e_hit);
        check("load_data", load_data, e_load);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        check("ready_pulse", ready, 0);
        check("mem_we_low", mem_write_en, 0);
        check("wb_count", wb_q.size(), e_wb);
        if (e_wb && wb_q.size() > 0) check("wb_addr_data", wb_q[0], e_wb_word);
    endtask

    initial begin
        #(PERIOD * 50000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rd_data;
        int          sel;

        rst_b = 1'b1; read = 1'b0; write = 1'b0; addr = '0; write_data = '0;
        mem[30'h10] = 32'h1122_3344;
        do_reset();
        check_idle_outputs("reset");

        // clean miss then hit on the same word
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        // store hit makes line dirty; conflicting load forces a writeback
        do_req(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        check("mem_0x40_after_wb", mem_rd(30'h10), 32'hDEAD_BEEF);
        // write miss allocates, following load hits
        do_req(1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D);
        do_req(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        // read+write together behaves as a write
        do_req(1'b1, 1'b1, 32'h0000_0008, 32'h5);
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h0);

        // reset in the middle of a fill
        read = 1'b1; write = 1'b0; addr = 32'h0000_0200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0; read = 1'b0;
        model_reset();
        check_idle_outputs("midfill_reset");
        do_req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);

        // random mix over a small address window to get hits and conflicts
        for (int i = 0; i < 200; i++) begin
            ra      = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom)};
            rd_data = $urandom;
            sel     = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            case (sel)
                0, 1:    do_req(1'b1, 1'b0, ra, rd_data);
                2:       do_req(1'b0, 1'b1, ra, rd_data);
                default: do_req(1'b1, 1'b1, ra, rd_data);
            endcase
        end

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        do_reset();
        check("hit_count_rst", hit_count, 0);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        check("hit_count_seq", hit_count, 2);
        check("miss_count_seq", miss_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16: number of direct-mapped one-word lines; power of two, range 2..256.
REQ-002 SHALL have parameter MEM_LAT, default 2: cycles from a stable mem_addr to valid mem_data_out; range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_b, input, 1: synchronous, active-high reset (1 = reset).
REQ-005 SHALL have port read, input, 1: core load request, held until ready.
REQ-006 SHALL have port write, input, 1: core store request, held until ready.
REQ-007 SHALL have port addr, input, 32: byte address; addr[1:0] ignored.
REQ-008 SHALL have port write_data, input, 32: store data.
REQ-009 SHALL have port load_data, output, 32: load result, valid while ready=1.
REQ-010 SHALL have port ready, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port hit, output, 1: qualifies ready; 1 = request hit.
REQ-012 SHALL have port mem_addr, output, 32: word-aligned memory address.
REQ-013 SHALL have port mem_data_in, output, 4x8 byte array [0:3]: write data to memory.
REQ-014 SHALL have port mem_data_out, input, 4x8 byte array [0:3]: read data from memory.
REQ-015 SHALL have port mem_write_en, output, 1: memory writes mem_data_in at mem_addr on the posedge where it is 1.

Function
REQ-016 Address split: index = addr[log2(NUM_LINES)+1:2]; tag = remaining upper bits; each line holds valid, dirty, tag, 32-bit word.
REQ-017 Byte lanes: lane 0 = word bits [31:24], lane 3 = bits [7:0], in both directions.
REQ-018 States: IDLE, WRITEBACK, FILL, RESP.
REQ-019 IDLE: request sampled when read or write is 1; both 1 is treated as write.
REQ-020 Hit, i.e. valid and tag match: go to RESP next cycle. Read returns the line word. Write updates the word and sets dirty. Memory is not touched.
REQ-021 Miss with victim valid and dirty: go to WRITEBACK, holding mem_addr = {victim tag, index, 2'b00} and mem_write_en = 1 for exactly one cycle, then go to FILL.
REQ-022 Miss with victim clean or invalid: go directly to FILL.
REQ-023 FILL: mem_addr = requested word address; wait MEM_LAT cycles via counter; capture mem_data_out; install line with valid=1, dirty=0; go to RESP.
REQ-024 Write miss: after fill, merge write_data into the line and set dirty=1 (write-allocate, write-back).
REQ-025 RESP: ready=1 for one cycle; hit reflects the sampled request; load_data = line word; then return to IDLE.
REQ-026 Latencies: hit ready 2 cycles after request; clean miss 2+MEM_LAT; dirty miss 3+MEM_LAT.
REQ-027 In IDLE a request is accepted on the cycle right after RESP; back-to-back requests need no bubble beyond RESP.
REQ-028 mem_write_en SHALL be 0 in every state except WRITEBACK.
REQ-029 addr, read, write and write_data are latched at acceptance; changes during a miss are ignored.

Reset
REQ-030 rst_b=1 at any posedge, including mid-miss: state=IDLE, all valid/dirty bits cleared, FILL counter cleared, ready=0, hit=0, mem_write_en=0, mem_addr=0, mem_data_in=0, load_data=0; pending writeback is discarded.

Configuration
REQ-031 Macro DCACHE_STATS_EN defined: adds outputs hit_count and miss_count, 32-bit each. Each increments on a RESP cycle with hit=1 or hit=0 respectively, wraps at 2^32, and resets to 0.
REQ-032 DCACHE_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-033 Shared package mips_pkg holds the dcache_state_t enum (IDLE, WRITEBACK, FILL, RESP) and the dcache_line_t struct (valid, dirty, tag, data).
REQ-034 Line storage SHALL be one sub-module dcache_array: synchronous write, combinational read, NUM_LINES entries; the FSM stays in dcache_ctrl.

Verification
REQ-035 Read 0x00000040 after reset, memory word 0x11223344, MEM_LAT=2: clean miss; ready at cycle 4 with hit=0, load_data=0x11223344; repeat read gives hit=1 at cycle 2.
REQ-036 Write 0x00000040 with 0xDEADBEEF after a line fill, then read 0x00000080 (same index, NUM_LINES=16): one mem_write_en pulse with mem_addr=0x40 and mem_data_in={DE,AD,BE,EF}, then fill from 0x80.
REQ-037 Write miss 0x00000104 with 0xCAFEF00D: fill completes, ready with hit=0, no memory write; a following read of 0x104 hits and returns 0xCAFEF00D.
REQ-038 read=1 and write=1 together on 0x8 with 0x5: treated as write; a following read returns 0x5.
REQ-039 rst_b=1 during FILL: next cycle IDLE with all outputs 0; a following read of the same address misses.
REQ-040 With DCACHE_STATS_EN: sequence miss, hit, hit gives hit_count=2 and miss_count=1.
